// File: rtl/firebird7_in_gate1_tessent_data_tdr_w19.sv
// IJTAG data TDR driving a downstream functional/ijtag mux.
// The top bit of the chain is the mux select; the lower WIDTH bits are the ijtag data.
module firebird7_in_gate1_tessent_data_tdr_w19 #(
  parameter  int WIDTH = 19,
  localparam int LEN   = WIDTH + 1
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] observe_data_in,
  output logic             ijtag_select,
  output logic [WIDTH-1:0] ijtag_data_out
);

  logic [LEN-1:0] shift_reg_r;
  logic [LEN-1:0] update_reg_r;
  logic [LEN-1:0] shift_next_s;
  logic [LEN-1:0] update_next_s;

  // Shift-register next state: capture wins over shift when both are requested.
  always_comb begin
    shift_next_s = shift_reg_r;
    if (ijtag_sel && ijtag_ce) begin
      shift_next_s = {update_reg_r[WIDTH], observe_data_in};
    end else if (ijtag_sel && ijtag_se) begin
      shift_next_s = {ijtag_si, shift_reg_r[LEN-1:1]};
    end else begin
      shift_next_s = shift_reg_r;
    end
  end

  // Update-register next state: samples the pre-edge chain contents.
  always_comb begin
    update_next_s = update_reg_r;
    if (ijtag_sel && ijtag_ue) begin
      update_next_s = shift_reg_r;
    end else begin
      update_next_s = update_reg_r;
    end
  end

  // State registers with synchronous reset taking priority over all operations.
  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      shift_reg_r  <= {LEN{1'b0}};
      update_reg_r <= {LEN{1'b0}};
    end else begin
      shift_reg_r  <= shift_next_s;
      update_reg_r <= update_next_s;
    end
  end

  assign ijtag_so       = shift_reg_r[0];
  assign ijtag_select   = update_reg_r[WIDTH];
  assign ijtag_data_out = update_reg_r[WIDTH-1:0];

endmodule
